// File: rtl/imem_pkg.sv
//============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               The S_CHECK state exists only when IMEM_LOADER_CHECKSUM_EN
//               is defined.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package imem_pkg;

  localparam int MAX_WORDS_DEF = 1024;  // instruction memory depth in words
  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 32;
  localparam int CNT_W         = 11;    // width of word_count / words_written

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
//============================================================================
// Module      : imem_loader_if
// Description : Control, byte-stream and memory-write bundle of the loader.
//               slave = loader side, master = host / memory side.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 32
) ();
  import imem_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  words_written;

  modport slave (
    input  start, base_addr, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written
  );

  modport master (
    output start, base_addr, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written
  );

endinterface

`default_nettype wire

// File: rtl/imem_byte_packer.sv
//============================================================================
// Module      : imem_byte_packer
// Description : 4-byte big-endian shift assembler. Holds the first three
//               bytes of a word; word_ready flags the 4th byte, at which
//               point word presents the full packed word.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module imem_byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [1:0]               count;
  logic [WORD_W-BYTE_W-1:0] hold;

  // Shift in accepted bytes; clear drops any partial word
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 2'd0;
      hold  <= '0;
    end else if (byte_valid) begin
      count <= count + 2'd1;
      hold  <= {hold[WORD_W-2*BYTE_W-1:0], byte_data};
    end
  end

  // First byte ends up in the top byte lane
  assign word       = {hold, byte_data};
  assign word_ready = byte_valid && (count == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
//============================================================================
// Module      : imem_loader
// Description : Receives a byte stream and writes it as big-endian 32-bit
//               words into instruction memory starting at base_addr.
//               Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t            state, state_nxt;
  logic              in_ready_c, busy_c, done_c, mem_we_c;
  logic              accept_start, bad_count, byte_fire;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  written_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [WORD_W-1:0] mem_wdata_r;
  logic              error_r;
  logic [WORD_W-1:0] packed_word;
  logic              word_ready;
  logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_r;
`endif

  assign accept_start = bus.start && (state == S_IDLE);
  assign bad_count    = (bus.word_count == '0) || (bus.word_count > MAX_CNT);
  assign byte_fire    = bus.in_valid && in_ready_c;
  assign last_word    = (written_r + CNT_W'(1)) == count_r;

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept_start),
    .byte_valid (byte_fire && (state == S_RECV)),
    .byte_data  (bus.in_data),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    mem_we_c   = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = bad_count ? S_DONE : S_RECV;
      end
      S_RECV: begin
        in_ready_c = 1'b1;
        if (word_ready) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (last_word) state_nxt = S_CHECK;
`else
        if (last_word) state_nxt = S_DONE;
`endif
        else           state_nxt = S_RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load parameters, write port registers, progress count and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r      <= '0;
      count_r     <= '0;
      written_r   <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      error_r     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_r       <= '0;
`endif
    end else begin
      if (accept_start) begin
        base_r    <= bus.base_addr;
        count_r   <= bus.word_count;
        written_r <= '0;
        error_r   <= bad_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_r     <= '0;
`endif
      end
      // Address/data are captured on the 4th byte and held until the next word
      if ((state == S_RECV) && word_ready) begin
        mem_addr_r  <= base_r + ADDR_W'({written_r, 2'b00});
        mem_wdata_r <= packed_word;
      end
      if (state == S_WRITE) written_r <= written_r + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ((state == S_RECV) && byte_fire) sum_r <= sum_r + bus.in_data;
      if ((state == S_CHECK) && byte_fire && ((sum_r + bus.in_data) != '0))
        error_r <= 1'b1;
`endif
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.busy          = busy_c;
  assign bus.done          = done_c;
  assign bus.mem_we        = mem_we_c;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.error         = error_r;
  assign bus.words_written = written_r;

endmodule

`default_nettype wire
